// File: rtl/car_sequencer.sv
// car_sequencer: one-entry prefetch buffer feeding a micro-step expander that
// turns each MSP430 instruction word into its ordered series of CAR step codes.

module car_sequencer #(
  parameter int CAR_BITS = 5,
  parameter bit TRAP_EN  = 1'b1
) (
  input  logic                MCLK,
  input  logic                RST_n,
  input  logic [15:0]         IW,
  input  logic                IW_valid,
  output logic                IW_ready,
  output logic [CAR_BITS-1:0] CAR,
  output logic                CAR_valid,
  output logic                LAST,
  input  logic                STEP_ready,
  output logic                ILLEGAL,
  output logic                BUSY
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef enum logic [3:0] {
    STEP_NONE     = 4'd0,
    FETCH_SRC_EXT = 4'd1,
    READ_SRC      = 4'd2,
    FETCH_DST_EXT = 4'd3,
    READ_DST      = 4'd4,
    EXEC          = 4'd5,
    WRITE_DST     = 4'd6,
    PUSH_SP       = 4'd7,
    POP_SR        = 4'd8,
    POP_PC        = 4'd9,
    JUMP          = 4'd10,
    TRAP          = 4'd15
  } step_e;

  // One bit per step kind; bit order is execution order, so the lowest set
  // bit is always the step currently presented on CAR.
  typedef logic [10:0] mask_t;
  localparam int M_FSX   = 0;
  localparam int M_RSRC  = 1;
  localparam int M_FDX   = 2;
  localparam int M_RDST  = 3;
  localparam int M_EXEC  = 4;
  localparam int M_WDST  = 5;
  localparam int M_PUSH  = 6;
  localparam int M_POPSR = 7;
  localparam int M_POPPC = 8;
  localparam int M_JUMP  = 9;
  localparam int M_TRAP  = 10;

  typedef struct packed {
    mask_t steps;
    logic  illegal;
  } decode_t;

  function automatic decode_t decode(input logic [15:0] iw);
    decode_t    d;
    logic [3:0] opc;
    logic [3:0] src;
    logic [2:0] op2;
    logic [1:0] as_mode;
    logic       is_jump, is_fmt1, is_fmt2, is_reti, ext_src, rd_src;
    opc     = iw[15:12];
    op2     = iw[9:7];
    as_mode = iw[5:4];
    is_jump = (iw[15:13] == 3'b001);
    is_fmt1 = (opc >= 4'h4);
    is_fmt2 = (opc == 4'h1) && (iw[11:10] == 2'b00) && (op2 != 3'd7);
    is_reti = is_fmt2 && (op2 == 3'd6);
    src     = is_fmt1 ? iw[11:8] : iw[3:0];
    // Constant-generator registers (R3, R2 in modes 10/11) and immediates never read memory
    ext_src = ((as_mode == 2'b01) && (src != 4'd3)) || ((as_mode == 2'b11) && (src == 4'd0));
    rd_src  = (as_mode != 2'b00) && (src != 4'd3) && !((src == 4'd2) && as_mode[1])
              && !((src == 4'd0) && (as_mode == 2'b11));
    d = '0;
    if (is_jump) begin
      d.steps[M_JUMP] = 1'b1;
    end else if (is_reti) begin
      d.steps[M_POPSR] = 1'b1;
      d.steps[M_POPPC] = 1'b1;
    end else if (is_fmt1 || is_fmt2) begin
      d.steps[M_FSX]  = ext_src;
      d.steps[M_RSRC] = rd_src;
      d.steps[M_EXEC] = 1'b1;
      if (is_fmt1) begin
        d.steps[M_FDX]  = iw[7];
        d.steps[M_RDST] = iw[7] && (opc != 4'h4);
        d.steps[M_WDST] = iw[7] && (opc != 4'h9) && (opc != 4'hB);
      end else begin
        d.steps[M_WDST] = !op2[2] && (as_mode != 2'b00);
        d.steps[M_PUSH] = (op2 == 3'd4) || (op2 == 3'd5);
      end
    end else begin
      d.illegal       = 1'b1;
      d.steps[M_TRAP] = TRAP_EN;
    end
    return d;
  endfunction

  function automatic step_e first_step(input mask_t m);
    step_e s;
    s = STEP_NONE;
    for (int i = M_TRAP; i >= 0; i--) begin
      if (m[i]) s = (i == M_TRAP) ? TRAP : step_e'(4'(i + 1));
    end
    return s;
  endfunction

  state_e              state_q, state_d;
  mask_t               mask_q, mask_d;
  logic [15:0]         buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [CAR_BITS-1:0] car_q;
  logic                car_valid_q, last_q, illegal_q;
  decode_t             dec;
  logic                step_fire, load;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    dec        = decode(buf_q);
    step_fire  = car_valid_q && STEP_ready;
    load       = buf_full_q && ((state_q == S_IDLE) || (step_fire && last_q));
    mask_d     = mask_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (load) begin
      mask_d = dec.steps;
    end else if (step_fire) begin
      mask_d = mask_q & (mask_q - mask_t'(1));
    end
    state_d = (mask_d != '0) ? S_RUN : S_IDLE;
    if (load) buf_full_d = 1'b0;
    if (IW_valid && !buf_full_q) begin
      buf_d      = IW;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge MCLK or negedge RST_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RST_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      buf_full_q  <= 1'b0;
      car_q       <= '0;
      car_valid_q <= 1'b0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      buf_full_q  <= buf_full_d;
      car_q       <= CAR_BITS'(first_step(mask_d));
      car_valid_q <= (mask_d != '0);
      last_q      <= (mask_d != '0) && ((mask_d & (mask_d - mask_t'(1))) == '0);
      illegal_q   <= load && dec.illegal;
    end
  end

  // NOTE: the buffer data word has no reset; it is only ever read while buf_full_q is set.
  always_ff @(posedge MCLK) begin
    buf_q <= buf_d;
  end

  assign IW_ready  = !buf_full_q;
  assign CAR       = car_q;
  assign CAR_valid = car_valid_q;
  assign LAST      = last_q;
  assign ILLEGAL   = illegal_q;
  assign BUSY      = buf_full_q || car_valid_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: two lanes (TRAP_EN=0 and TRAP_EN=1), each tracked by a
// queue-level reference model, with directed scenarios followed by random traffic.

module tb_car_sequencer;

  localparam int CB = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0]   iw         [2];
  logic          iw_valid   [2];
  logic          step_ready [2];
  logic          iw_ready   [2];
  logic [CB-1:0] car        [2];
  logic          car_valid  [2];
  logic          last       [2];
  logic          illegal    [2];
  logic          busy       [2];

  car_sequencer #(.CAR_BITS(CB), .TRAP_EN(1'b0)) u_dut0 (
    .MCLK(clk), .RST_n(rst_n), .IW(iw[0]), .IW_valid(iw_valid[0]), .IW_ready(iw_ready[0]),
    .CAR(car[0]), .CAR_valid(car_valid[0]), .LAST(last[0]), .STEP_ready(step_ready[0]),
    .ILLEGAL(illegal[0]), .BUSY(busy[0])
  );

  car_sequencer #(.CAR_BITS(CB), .TRAP_EN(1'b1)) u_dut1 (
    .MCLK(clk), .RST_n(rst_n), .IW(iw[1]), .IW_valid(iw_valid[1]), .IW_ready(iw_ready[1]),
    .CAR(car[1]), .CAR_valid(car_valid[1]), .LAST(last[1]), .STEP_ready(step_ready[1]),
    .ILLEGAL(illegal[1]), .BUSY(busy[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Step list of one instruction, four bits per step, first step in the low nibble.
  function automatic int expand(input logic [15:0] w, input bit te,
                                output logic [31:0] lst, output bit ill);
    int         n;
    logic [3:0] hi, s;
    logic [2:0] op;
    logic [1:0] am;
    bit         jmp, f1, f2, ad;
    n   = 0;
    lst = '0;
    ill = 1'b0;
    hi  = w[15:12];
    op  = w[9:7];
    am  = w[5:4];
    ad  = w[7];
    jmp = (hi == 4'h2) || (hi == 4'h3);
    f1  = (hi >= 4'h4);
    f2  = (hi == 4'h1) && (w[11:10] == 2'b00) && (op != 3'd7);
    s   = f1 ? w[11:8] : w[3:0];
    if (jmp) begin
      lst[3:0] = 4'd10; n = 1;
    end else if (f2 && op == 3'd6) begin
      lst[7:0] = 8'h98; n = 2;
    end else if (f1 || f2) begin
      if ((am == 2'd1 && s != 4'd3) || (am == 2'd3 && s == 4'd0)) begin lst[4*n +: 4] = 4'd1; n++; end
      if (am != 2'd0 && s != 4'd3 && !(s == 4'd2 && am >= 2'd2) && !(s == 4'd0 && am == 2'd3)) begin
        lst[4*n +: 4] = 4'd2; n++;
      end
      if (f1 && ad) begin
        lst[4*n +: 4] = 4'd3; n++;
        if (hi != 4'h4) begin lst[4*n +: 4] = 4'd4; n++; end
      end
      lst[4*n +: 4] = 4'd5; n++;
      if (f1 && ad && hi != 4'h9 && hi != 4'hB) begin lst[4*n +: 4] = 4'd6; n++; end
      if (f2 && op <= 3'd3 && am != 2'd0)        begin lst[4*n +: 4] = 4'd6; n++; end
      if (f2 && (op == 3'd4 || op == 3'd5))      begin lst[4*n +: 4] = 4'd7; n++; end
    end else begin
      ill = 1'b1;
      if (te) begin lst[3:0] = 4'd15; n = 1; end
    end
    return n;
  endfunction

  // Reference model state per lane: buffer slot plus the current step list.
  bit          mfull [2];
  logic [15:0] mbuf  [2];
  logic [31:0] mlst  [2];
  int          mn    [2];
  int          midx  [2];
  bit          mill  [2];
  bit          took  [2];

  function automatic bit ev(input int k);
    return midx[k] < mn[k];
  endfunction

  task automatic model_edge(input int k);
    bit          fire, acc, ill;
    logic [31:0] l;
    fire = ev(k) && (step_ready[k] === 1'b1);
    acc  = (iw_valid[k] === 1'b1) && !mfull[k];
    if (fire) midx[k]++;
    mill[k] = 1'b0;
    if (mfull[k] && midx[k] >= mn[k]) begin
      mn[k]    = expand(mbuf[k], k == 1, l, ill);
      mlst[k]  = l;
      midx[k]  = 0;
      mill[k]  = ill;
      mfull[k] = 1'b0;
    end
    if (acc) begin
      mbuf[k]  = iw[k];
      mfull[k] = 1'b1;
    end
    took[k] = acc;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          mfull[k] = 1'b0; mn[k] = 0; midx[k] = 0; mill[k] = 1'b0; took[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) model_edge(k);
      end
    end
  end

  // Every-cycle comparison of both lanes against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("lane%0d IW_ready", k), iw_ready[k], !mfull[k]);
          check($sformatf("lane%0d CAR_valid", k), car_valid[k], ev(k));
          check($sformatf("lane%0d ILLEGAL", k), illegal[k], mill[k]);
          check($sformatf("lane%0d BUSY", k), busy[k], mfull[k] || ev(k));
          if (ev(k)) begin
            check($sformatf("lane%0d CAR", k), car[k], mlst[k][4*midx[k] +: 4]);
            check($sformatf("lane%0d LAST", k), last[k], midx[k] == mn[k] - 1);
          end
        end
      end
    end
  end

  // Random-phase driver: feeds each lane from its own list of pending words.
  logic [15:0] pend [2][256];
  int          p_wr [2];
  int          p_rd [2];
  bit          drv_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int k = 0; k < 2; k++) begin
          if (took[k]) begin
            p_rd[k]++;
            iw_valid[k] = 1'b0;
          end
          if (!iw_valid[k] && p_rd[k] != p_wr[k] && $urandom_range(0, 2) != 0) begin
            iw[k]       = pend[k][p_rd[k]];
            iw_valid[k] = 1'b1;
          end
          step_ready[k] = ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  task automatic drive(input logic [15:0] w, input bit v);
    for (int k = 0; k < 2; k++) begin
      iw[k]       = w;
      iw_valid[k] = v;
    end
  endtask

  task automatic set_ready(input bit r);
    for (int k = 0; k < 2; k++) step_ready[k] = r;
  endtask

  task automatic see(input int k, input bit v, input int c, input bit l, input string nm);
    check($sformatf("%s lane%0d valid", nm, k), car_valid[k], v);
    if (v) begin
      check($sformatf("%s lane%0d CAR", nm, k), car[k], c);
      check($sformatf("%s lane%0d LAST", nm, k), last[k], l);
    end
  endtask

  task automatic see_both(input bit v, input int c, input bit l, input string nm);
    for (int k = 0; k < 2; k++) see(k, v, c, l, nm);
  endtask

  task automatic ready_both(input bit r, input string nm);
    for (int k = 0; k < 2; k++) check($sformatf("%s lane%0d IW_ready", nm, k), iw_ready[k], r);
  endtask

  task automatic reset_values(input string nm);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s lane%0d CAR", nm, k), car[k], 0);
      check($sformatf("%s lane%0d CAR_valid", nm, k), car_valid[k], 0);
      check($sformatf("%s lane%0d LAST", nm, k), last[k], 0);
      check($sformatf("%s lane%0d ILLEGAL", nm, k), illegal[k], 0);
      check($sformatf("%s lane%0d BUSY", nm, k), busy[k], 0);
      check($sformatf("%s lane%0d IW_ready", nm, k), iw_ready[k], 1);
    end
  endtask

  task automatic pin(input logic [15:0] w, input bit te, input logic [31:0] el, input int en);
    logic [31:0] l;
    bit          ill;
    int          n;
    n = expand(w, te, l, ill);
    check($sformatf("model %h te%0d steps", w, te), l, el);
    check($sformatf("model %h te%0d count", w, te), n, en);
  endtask

  function automatic logic [15:0] rand_iw();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       r[15:10] = 6'b000100;
      1:       r[15:13] = 3'b001;
      2:       r[15:12] = 4'h0;
      3:       r[15:12] = 4'h1;
      default: if (r[15:12] < 4'h4) r[15] = 1'b1;
    endcase
    if ($urandom_range(0, 1) != 0) r[3:0] = 4'($urandom_range(0, 3));
    if ($urandom_range(0, 1) != 0 && r[15:12] >= 4'h4) r[11:8] = 4'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit pending;
    rst_n = 1'b1;
    drive(16'h0000, 1'b0);
    set_ready(1'b1);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_values("reset");

    pin(16'h4586, 1'b1, 32'h653, 3);
    pin(16'h5437, 1'b1, 32'h52,  2);
    pin(16'h9398, 1'b1, 32'h543, 3);
    pin(16'h12B0, 1'b1, 32'h751, 3);
    pin(16'h1300, 1'b1, 32'h98,  2);
    pin(16'h3C00, 1'b1, 32'hA,   1);
    pin(16'h0000, 1'b1, 32'hF,   1);
    pin(16'h0000, 1'b0, 32'h0,   0);

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // MOV R5,2(R6): two-cycle latency, then 3,5,6
    drive(16'h4586, 1'b1);
    @(negedge clk); drive(16'h4586, 1'b0); ready_both(1'b0, "A held"); see_both(1'b0, 0, 1'b0, "A latency");
    @(negedge clk); see_both(1'b1, 3, 1'b0, "A s1");
    @(negedge clk); see_both(1'b1, 5, 1'b0, "A s2");
    @(negedge clk); see_both(1'b1, 6, 1'b1, "A s3");
    @(negedge clk); see_both(1'b0, 0, 1'b0, "A done");

    // Back-to-back 0x5437 then 0x9398
    drive(16'h5437, 1'b1);
    @(negedge clk); drive(16'h9398, 1'b1); ready_both(1'b0, "B buffered");
    @(negedge clk); see_both(1'b1, 2, 1'b0, "B s1"); ready_both(1'b1, "B freed");
    @(negedge clk); see_both(1'b1, 5, 1'b1, "B s2"); ready_both(1'b0, "B second held"); drive(16'h9398, 1'b0);
    @(negedge clk); see_both(1'b1, 3, 1'b0, "B no bubble");
    @(negedge clk); see_both(1'b1, 4, 1'b0, "B s4");
    @(negedge clk); see_both(1'b1, 5, 1'b1, "B s5");
    @(negedge clk); see_both(1'b0, 0, 1'b0, "B done");

    // CALL #imm with a three-cycle stall on step 2
    drive(16'h12B0, 1'b1);
    @(negedge clk); drive(16'h12B0, 1'b0);
    @(negedge clk); see_both(1'b1, 1, 1'b0, "C s1");
    @(negedge clk); see_both(1'b1, 5, 1'b0, "C s2"); set_ready(1'b0);
    repeat (3) begin
      @(negedge clk); see_both(1'b1, 5, 1'b0, "C stall");
    end
    set_ready(1'b1);
    @(negedge clk); see_both(1'b1, 7, 1'b1, "C s3");
    @(negedge clk); see_both(1'b0, 0, 1'b0, "C done");

    // RETI then JMP
    drive(16'h1300, 1'b1);
    @(negedge clk); drive(16'h3C00, 1'b1);
    @(negedge clk); see_both(1'b1, 8, 1'b0, "D pop_sr");
    @(negedge clk); see_both(1'b1, 9, 1'b1, "D pop_pc"); drive(16'h3C00, 1'b0);
    @(negedge clk); see_both(1'b1, 10, 1'b1, "D jump");
    @(negedge clk); see_both(1'b0, 0, 1'b0, "D done");

    // Illegal word: lane1 traps, lane0 discards; both pulse ILLEGAL once
    drive(16'h0000, 1'b1);
    @(negedge clk); drive(16'h0000, 1'b0);
    for (int k = 0; k < 2; k++) check($sformatf("E pre lane%0d ILLEGAL", k), illegal[k], 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("E pulse lane%0d ILLEGAL", k), illegal[k], 1);
    see(1, 1'b1, 15, 1'b1, "E trap");
    see(0, 1'b0, 0, 1'b0, "E discard");
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("E post lane%0d ILLEGAL", k), illegal[k], 0);
    see_both(1'b0, 0, 1'b0, "E idle");
    drive(16'h3C00, 1'b1);
    @(negedge clk); drive(16'h3C00, 1'b0);
    @(negedge clk); see_both(1'b1, 10, 1'b1, "E next");
    @(negedge clk);

    // Reset during step 2 with a second word buffered
    drive(16'h4586, 1'b1);
    @(negedge clk);
    @(negedge clk); see_both(1'b1, 3, 1'b0, "F s1");
    @(negedge clk); see_both(1'b1, 5, 1'b0, "F s2"); ready_both(1'b0, "F buffered");
    #1 rst_n = 1'b0;
    #1 reset_values("F async reset");
    drive(16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ready_both(1'b1, "F released");
    repeat (3) @(negedge clk);
    see_both(1'b0, 0, 1'b0, "F no residue");

    // Random traffic, same word stream into both lanes
    for (int i = 0; i < 250; i++) begin
      logic [15:0] w;
      w = rand_iw();
      for (int k = 0; k < 2; k++) begin
        pend[k][p_wr[k]] = w;
        p_wr[k]++;
      end
    end
    drv_en = 1'b1;
    cycles = 0;
    pending = 1'b1;
    while (pending && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      pending = 1'b0;
      for (int k = 0; k < 2; k++)
        if (p_rd[k] != p_wr[k] || iw_valid[k] || mfull[k] || ev(k)) pending = 1'b1;
    end
    check("random drain within budget", !pending, 1);
    drv_en = 1'b0;
    drive(16'h0000, 1'b0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
